// File: rtl/ysyx_22040088_pkg.sv
// Shared widths, reset vector and the fetch-entry layout handed from fetch to decode.
package ysyx_22040088_pkg;

    localparam int          XLEN     = 64;
    localparam int          ILEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_22040088_sync_fifo.sv
// Generic synchronous FIFO with flush; registered storage, read data is the head slot.
// Latency: a push is visible at the head one cycle later (no bypass).
// Backpressure: full/count let the producer throttle; push on full without pop is illegal.
module ysyx_22040088_sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] rdata
);
    import ysyx_22040088_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // On full, push+pop writes the slot being read out this same cycle.
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full && !pop));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(DEPTH));

endmodule

// File: rtl/ysyx_22040088_fetch_q.sv
// Decoupled fetch: credit-limited imem requests, in-order {inst, pc} queue, redirect flush.
// Latency: imem response to out_valid is 1 cycle; redirect target appears on imem_req_addr next cycle.
// Backpressure: requests stop once in-flight plus buffered fetches reach DEPTH; out_ready stalls the head.
module ysyx_22040088_fetch_q #(
    parameter int              XLEN     = ysyx_22040088_pkg::XLEN,
    parameter int              ILEN     = ysyx_22040088_pkg::ILEN,
    parameter int              DEPTH    = ysyx_22040088_pkg::DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(ysyx_22040088_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc
);
    import ysyx_22040088_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ILEN + XLEN;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic [EW-1:0]   fifo_rdata;
    entry_t          push_entry, head_entry;
    logic [CW:0]     in_use;
    logic            req_fire, rsp_keep, pop;
    logic [XLEN-1:0] redirect_tgt;

    // Credit covers both in-flight requests and buffered entries, so a kept response always fits.
    assign in_use         = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && (in_use < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    assign pop            = out_valid && out_ready;
    assign redirect_tgt   = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        // Everything still in flight after a redirect belongs to the old stream.
        discard_d = discard_q;
        if (redirect_valid) begin
            discard_d = outstanding_d;
        end else if (imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        rsp_pc_d = rsp_pc_q;
        if (redirect_valid) begin
            rsp_pc_d = redirect_tgt;
        end else if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign push_entry.inst = imem_rsp_data;
    assign push_entry.pc   = rsp_pc_q;

    ysyx_22040088_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .wdata (push_entry),
        .pop   (pop),
        .flush (redirect_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .rdata (fifo_rdata)
    );

    assign head_entry = entry_t'(fifo_rdata);
    assign out_valid  = !fifo_empty;
    assign out_inst   = head_entry.inst;
    assign out_pc     = head_entry.pc;

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        in_use <= (CW + 1)'(DEPTH));
    a_full_no_req: assert property (@(posedge clk) disable iff (rst)
        fifo_full |-> !imem_req_valid);
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        discard_q <= outstanding_q);

endmodule

// File: tb/tb_ysyx_22040088_fetch_q.sv
// Bench for the fetch queue: behavioural memory plus an epoch-tagged model of which fetches survive.
module tb_ysyx_22040088_fetch_q;
    import ysyx_22040088_pkg::*;

    localparam int          TB_DEPTH = 4;
    localparam logic [63:0] RPC      = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;

    always #5 clk = ~clk;

    ysyx_22040088_fetch_q #(
        .XLEN     (64),
        .ILEN     (32),
        .DEPTH    (TB_DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    req_t        memq[$];
    ent_t        expq[$];
    logic [63:0] pops[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          epoch = 0;
    int          nfire = 0;
    int          npop  = 0;
    logic [63:0] mfetch;
    logic        rst_prev;
    logic        want_first;
    logic [63:0] first_pc;

    function automatic logic [31:0] img(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model across the rising edge.
    task automatic cycle(input logic rdy, input logic ordy, input logic redir, input logic [63:0] rpc);
        req_t r;
        logic rv, fire, pop, exp_v;
        int   outst;
        r = '{addr: 64'h0, due: 0, epoch: 0};
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rv = 1'b0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            r  = memq.pop_front();
            rv = 1'b1;
        end
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? img(r.addr) : $urandom();
        outst = memq.size() + (rv ? 1 : 0);
        exp_v = !rst && ((outst + expq.size()) < TB_DEPTH);
        #1;
        check_eq("req_valid", 64'(imem_req_valid), 64'(exp_v));
        check_eq("req_addr", imem_req_addr, mfetch);
        check_eq("out_valid", 64'(out_valid), 64'(expq.size() != 0));
        if (expq.size() != 0 && out_valid) begin
            check_eq("out_pc", out_pc, expq[0].pc);
            check_eq("out_inst", 64'(out_inst), 64'(expq[0].inst));
        end
        if (rst_prev) begin
            check_eq("rst_out_inst", 64'(out_inst), 64'h0);
            check_eq("rst_out_pc", out_pc, 64'h0);
        end

        fire = imem_req_valid && rdy;
        pop  = out_valid && ordy;
        if (fire) nfire++;
        if (pop) begin
            npop++;
            pops.push_back(out_pc);
            if (want_first) begin
                first_pc   = out_pc;
                want_first = 1'b0;
            end
        end
        if (rst) begin
            memq.delete();
            expq.delete();
            mfetch     = RPC;
            epoch++;
            first_pc   = '1;
            want_first = 1'b1;
        end else begin
            if (fire) begin
                memq.push_back('{addr: mfetch, due: cyc + lat, epoch: epoch});
                mfetch = mfetch + 64'd4;
            end
            if (pop && expq.size() != 0) void'(expq.pop_front());
            if (redir) begin
                expq.delete();
                mfetch     = {rpc[63:2], 2'b00};
                epoch++;
                first_pc   = '1;
                want_first = 1'b1;
            end else if (rv && r.epoch == epoch) begin
                expq.push_back('{inst: img(r.addr), pc: r.addr});
            end
        end
        rst_prev = rst;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b0;
        mfetch         = RPC;
        rst_prev       = 1'b0;
        want_first     = 1'b0;
        first_pc       = '1;
        @(posedge clk);
        @(negedge clk);
        rst_prev = 1'b1;
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 64'h0);

        // Streaming with a 1-cycle memory: one instruction per cycle once the pipe fills.
        rst  = 1'b0;
        lat  = 1;
        npop = 0;
        pops.delete();
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 64'h0);
        check_eq("thru_count", 64'(npop), 64'd18);
        for (int i = 0; i < 3; i++)
            check_eq("thru_pc", (pops.size() > i) ? pops[i] : '1, RPC + 64'(4 * i));

        // Reset pulse with fetches in flight, then stall decode.
        rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 64'h0);
        rst   = 1'b0;
        nfire = 0;
        pops.delete();
        repeat (12) cycle(1'b1, 1'b0, 1'b0, 64'h0);
        check_eq("stall_fires", 64'(nfire), 64'(TB_DEPTH));
        check_eq("stall_req_valid", 64'(imem_req_valid), 64'h0);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++)
            check_eq("drain_pc", (pops.size() > i) ? pops[i] : '1, RPC + 64'(4 * i));

        // Latency 2 keeps a fire and a response in the redirect cycle.
        lat = 2;
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b1, 64'h8000_0100);
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 64'h0);
        check_eq("redir_first_pc", first_pc, 64'h8000_0100);

        lat = 3;
        repeat (6) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b1, 64'h8000_0203);
        repeat (15) cycle(1'b1, 1'b1, 1'b0, 64'h0);
        check_eq("redir_align_pc", first_pc, 64'h8000_0200);

        cycle(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9);
        repeat (15) cycle(1'b1, 1'b1, 1'b0, 64'h0);
        check_eq("wrap_first_pc", first_pc, 64'hFFFF_FFFF_FFFF_FFF8);

        // Random ready/stall/redirect traffic over several memory latencies.
        for (int k = 0; k < 8; k++) begin
            lat = (k < 4) ? 3 : $urandom_range(1, 4);
            repeat (100)
                cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                      1'($urandom_range(0, 39) == 0), {$urandom(), $urandom()});
        end

        // Final reset restarts fetch at the reset vector.
        rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 64'h0);
        rst = 1'b0;
        lat = 1;
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 64'h0);
        check_eq("restart_pc", first_pc, RPC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
